// File: rtl/obstacle_scheduler.sv
// Play-screen sequencer: spawns obstacles, steps them toward the hero every game tick,
// drives the hero jump animation from keypad presses and resolves clear/hit outcomes.
module obstacle_scheduler #(
  parameter int unsigned TICK_DIV   = 5_000_000,
  parameter int unsigned N_POS      = 4,
  parameter int unsigned JUMP_TICKS = 3,
  parameter int unsigned WIN_SCORE  = 20,
  parameter logic [4:0]  JUMP_KEY   = 5'd2,
  parameter logic [2:0]  PLAY_CODE  = 3'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] presente,
  input  logic       keypad_pressed,
  input  logic [4:0] key,
  output logic [3:0] tipo_obs,
  output logic [2:0] obs_pos,
  output logic [1:0] var_h,
  output logic [7:0] score,
  output logic [1:0] W_or_L
);

  localparam int             TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  TICK_ZERO = {TW{1'b0}};
  localparam logic [2:0]     POS_MAX   = 3'(N_POS - 1);
  localparam logic [2:0]     JT        = 3'(JUMP_TICKS);
  localparam logic [7:0]     WIN_S     = 8'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [TW-1:0]   tick_cnt_r, tick_cnt_s;
  logic [2:0]      jump_cnt_r, jump_cnt_s;
  logic [7:0]      lfsr_r, lfsr_s;
  logic            press_q_r, press_q_s;
  logic [3:0]      tipo_r, tipo_s;
  logic [2:0]      pos_r, pos_s;
  logic [1:0]      var_h_r, var_h_s;
  logic [7:0]      score_r, score_s;
  logic [1:0]      wl_r, wl_s;
  logic            press_s, tick_s, jump_req_s, end_s;

  // Fibonacci LFSR, taps 8,6,5,4; non-zero seed keeps it out of the lock-up state
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Glyph 0 means "no obstacle", so a zero draw is promoted to type 1
  function automatic logic [3:0] obs_type(input logic [3:0] l);
    return (l == 4'h0) ? 4'h1 : l;
  endfunction

  // Next-state and next-output logic for the whole game sequencer
  always_comb begin
    state_s    = state_r;
    tick_cnt_s = tick_cnt_r;
    jump_cnt_s = jump_cnt_r;
    tipo_s     = tipo_r;
    pos_s      = pos_r;
    var_h_s    = var_h_r;
    score_s    = score_r;
    wl_s       = wl_r;
    lfsr_s     = lfsr_step(lfsr_r);
    press_q_s  = keypad_pressed;
    press_s    = keypad_pressed & ~press_q_r;
    tick_s     = 1'b0;
    jump_req_s = 1'b0;
    end_s      = 1'b0;
    if ((state_r != IDLE) && (presente != PLAY_CODE)) begin
      state_s    = IDLE;
      tipo_s     = 4'h0;
      pos_s      = 3'd0;
      var_h_s    = 2'b00;
      jump_cnt_s = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          tipo_s     = 4'h0;
          pos_s      = 3'd0;
          var_h_s    = 2'b00;
          jump_cnt_s = 3'd0;
          if (presente == PLAY_CODE) begin
            state_s    = RUN;
            score_s    = 8'd0;
            wl_s       = 2'b00;
            tick_cnt_s = TICK_ZERO;
            pos_s      = POS_MAX;
            tipo_s     = obs_type(lfsr_r[3:0]);
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          tick_s     = (tick_cnt_r == TICK_LAST);
          jump_req_s = press_s & (key == JUMP_KEY) & (jump_cnt_r == 3'd0);
          if (tick_s) begin
            tick_cnt_s = TICK_ZERO;
            if (pos_r != 3'd0) begin
              pos_s = pos_r - 3'd1;
            end else if (jump_cnt_r != 3'd0) begin
              score_s = score_r + 8'd1;
              pos_s   = POS_MAX;
              tipo_s  = obs_type(lfsr_r[3:0]);
              if (score_s == WIN_S) begin
                wl_s  = 2'b01;
                end_s = 1'b1;
              end else begin
                end_s = 1'b0;
              end
            end else begin
              wl_s  = 2'b10;
              end_s = 1'b1;
            end
            // Decrement uses the pre-tick count; landing happens on the last airborne tick
            if (jump_cnt_r != 3'd0) begin
              jump_cnt_s = jump_cnt_r - 3'd1;
              var_h_s    = (jump_cnt_r == 3'd1) ? 2'b00 : var_h_r;
            end else begin
              jump_cnt_s = jump_cnt_r;
            end
          end else begin
            tick_cnt_s = tick_cnt_r + TW'(1);
          end
          if (end_s) begin
            state_s = DONE;
          end else if (jump_req_s) begin
            state_s    = RUN;
            jump_cnt_s = JT;
            var_h_s    = 2'b01;
          end else begin
            state_s = RUN;
          end
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      tick_cnt_r <= TICK_ZERO;
      jump_cnt_r <= 3'd0;
      lfsr_r     <= 8'hA5;
      press_q_r  <= 1'b0;
      tipo_r     <= 4'h0;
      pos_r      <= 3'd0;
      var_h_r    <= 2'b00;
      score_r    <= 8'd0;
      wl_r       <= 2'b00;
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      jump_cnt_r <= jump_cnt_s;
      lfsr_r     <= lfsr_s;
      press_q_r  <= press_q_s;
      tipo_r     <= tipo_s;
      pos_r      <= pos_s;
      var_h_r    <= var_h_s;
      score_r    <= score_s;
      wl_r       <= wl_s;
    end
  end

  assign tipo_obs = tipo_r;
  assign obs_pos  = pos_r;
  assign var_h    = var_h_r;
  assign score    = score_r;
  assign W_or_L   = wl_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: game-rule model compared every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_obstacle_scheduler;

  localparam int TICK_DIV = 4;
  localparam int N_POS    = 4;
  localparam int JT       = 2;
  localparam int WIN      = 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] presente;
  logic       keypad_pressed;
  logic [4:0] key;
  logic [3:0] tipo_obs;
  logic [2:0] obs_pos;
  logic [1:0] var_h;
  logic [7:0] score;
  logic [1:0] W_or_L;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // game model: phase 0 idle, 1 playing, 2 finished
  int m_phase, m_cnt, m_pos, m_typ, m_air, m_hv, m_score, m_wl, m_lfsr, m_prevkp;

  obstacle_scheduler #(
    .TICK_DIV(TICK_DIV), .N_POS(N_POS), .JUMP_TICKS(JT), .WIN_SCORE(WIN),
    .JUMP_KEY(5'd2), .PLAY_CODE(3'd3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .presente(presente), .keypad_pressed(keypad_pressed),
    .key(key), .tipo_obs(tipo_obs), .obs_pos(obs_pos), .var_h(var_h),
    .score(score), .W_or_L(W_or_L)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  function automatic int new_type(input int l);
    return ((l & 15) == 0) ? 1 : (l & 15);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_pos = 0; m_typ = 0; m_air = 0; m_hv = 0;
    m_score = 0; m_wl = 0; m_lfsr = 8'hA5; m_prevkp = 0;
  endtask

  task automatic model_step(input int pres, input int kp, input int k);
    int  lf;
    bit  press, tick, jump;
    lf = m_lfsr;
    press = (kp != 0) && (m_prevkp == 0);
    m_prevkp = kp;
    if (m_phase == 0) begin
      if (pres == 3) begin
        m_phase = 1; m_score = 0; m_wl = 0; m_cnt = 0; m_air = 0;
        m_pos = N_POS - 1; m_typ = new_type(lf);
      end else begin
        m_typ = 0; m_pos = 0; m_hv = 0;
      end
    end else if (pres != 3) begin
      m_phase = 0; m_typ = 0; m_pos = 0; m_hv = 0; m_air = 0;
    end else if (m_phase == 1) begin
      m_cnt++;
      tick = (m_cnt == TICK_DIV);
      if (tick) m_cnt = 0;
      jump = press && (k == 2) && (m_air == 0);
      if (tick) begin
        if (m_pos > 0) m_pos--;
        else if (m_air > 0) begin
          m_score++; m_pos = N_POS - 1; m_typ = new_type(lf);
          if (m_score == WIN) begin m_wl = 1; m_phase = 2; end
        end else begin
          m_wl = 2; m_phase = 2;
        end
        if (m_air > 0) begin
          m_air--;
          if (m_air == 0) m_hv = 0;
        end
      end
      if (jump && m_phase == 1) begin m_air = JT; m_hv = 1; end
    end
    m_lfsr = lfsr_next(lf);
  endtask

  // one clock per iteration: inputs change on the falling edge, model steps on the rising edge
  task automatic run(input int n, input int pres, input int kp, input int k);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      presente = 3'(pres); keypad_pressed = kp[0]; key = 5'(k);
      @(posedge clk);
      model_step(pres, kp, k);
    end
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tipo"}, tipo_obs, 0);
    chk({tag, "_pos"}, obs_pos, 0);
    chk({tag, "_varh"}, var_h, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_wl"}, W_or_L, 0);
  endtask

  // reset asserted just after the edge the model already stepped on
  task automatic pulse_reset(input string tag);
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk_zero(tag);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_tipo", tipo_obs, m_typ);
      chk("m_pos", obs_pos, m_pos);
      chk("m_varh", var_h, m_hv);
      chk("m_score", score, m_score);
      chk("m_wl", W_or_L, m_wl);
    end
  end

  initial begin
    presente = 3'd0; keypad_pressed = 1'b0; key = 5'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_zero("rst");
    #1 rst_n = 1'b1;

    // lose: no keys, obstacle walks in and hits
    run(1, 3, 0, 0);
    chk("entry_tipo", tipo_obs, 5);
    chk("entry_pos", obs_pos, 3);
    run(4, 3, 0, 0);  chk("t1_pos", obs_pos, 2);
    run(4, 3, 0, 0);  chk("t2_pos", obs_pos, 1);
    run(4, 3, 0, 0);  chk("t3_pos", obs_pos, 0);
    run(4, 3, 0, 0);  chk("hit_wl", W_or_L, 2); chk("hit_pos", obs_pos, 0);
    run(4, 3, 1, 2);  chk("done_wl", W_or_L, 2); chk("done_varh", var_h, 0);

    // W_or_L held through IDLE, cleared on re-entry
    run(3, 0, 0, 0);  chk("idle_wl", W_or_L, 2); chk("idle_pos", obs_pos, 0);
    run(1, 3, 0, 0);  chk("re_wl", W_or_L, 0); chk("re_score", score, 0); chk("re_pos", obs_pos, 3);
    run(4, 3, 0, 0);  chk("re_t1_pos", obs_pos, 2);
    pulse_reset("midrun");
    run(2, 0, 0, 0);  chk("post_rst_pos", obs_pos, 0);
    pulse_reset("idle");

    // clear twice to win
    run(1, 3, 0, 0);  chk("w_entry_tipo", tipo_obs, 5);
    run(9, 3, 0, 0);
    run(1, 3, 1, 2);  chk("w_jump_varh", var_h, 1);
    run(2, 3, 0, 0);  chk("w_t3_pos", obs_pos, 0); chk("w_t3_varh", var_h, 1);
    run(4, 3, 0, 0);
    chk("w_c1_score", score, 1); chk("w_c1_pos", obs_pos, 3);
    chk("w_c1_varh", var_h, 0); chk("w_c1_tipo_nz", int'(tipo_obs != 4'h0), 1);
    run(9, 3, 0, 0);
    run(1, 3, 1, 2);
    run(6, 3, 0, 0);  chk("w_c2_score", score, 2); chk("w_c2_wl", W_or_L, 1);
    run(8, 3, 1, 2);  chk("w_frz_pos", obs_pos, 3); chk("w_frz_wl", W_or_L, 1);
    run(2, 0, 0, 0);  chk("w_idle_wl", W_or_L, 1); chk("w_idle_tipo", tipo_obs, 0);

    // airborne re-press, long hold, wrong key
    run(1, 3, 0, 0);
    run(1, 3, 1, 2);
    run(1, 3, 0, 2);
    run(1, 3, 1, 2);
    run(5, 3, 0, 2);  chk("j_land_varh", var_h, 0); chk("j_land_pos", obs_pos, 1);
    run(1, 3, 0, 0);
    run(7, 3, 1, 2);  chk("h_score", score, 1); chk("h_varh", var_h, 0);
    run(13, 3, 1, 2); chk("h_pos", obs_pos, 0); chk("h_still_ground", var_h, 0);
    run(1, 3, 0, 0);
    run(1, 3, 1, 5);  chk("wrongkey_varh", var_h, 0);
    run(1, 3, 0, 0);  chk("wrongkey_wl", W_or_L, 2); chk("wrongkey_score", score, 1);
    run(3, 0, 0, 0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
